multi_deck_shuffler: RTL and testbench
======================================

Name: multi_deck_shuffler

Overview:
Parametrised successor to the single-deck embaralhador FSM. Holds NUM_DECKS x 52 card values in internal RAM and initialises them on request. Performs a Fisher-Yates shuffle driven by a seeded 16-bit LFSR; the seed comes from the free-running reset counter. Then deals cards one at a time over a draw handshake to the card-adder FSM.

Parameters:
NUM_DECKS, 1, number of 52-card decks; legal range 1..8
CARD_W, 4, card value width; values 1..13 (1 = ace, 11..13 = faces)
ADDR_W, 9, RAM address and dealt-count width; must satisfy 2^ADDR_W >= 52*NUM_DECKS
SEED_W, 12, width of i_Seed; must be <= 16

Ports:
clk  in  1  system clock
i_Reset  in  1  synchronous reset, active-high
i_Start  in  1  one-cycle pulse: latch seed, re-initialise deck, shuffle
i_Seed  in  SEED_W  LFSR seed, sampled only on the i_Start cycle
i_Draw  in  1  one-cycle pulse: request next card
o_Card  out  CARD_W  dealt card value, held until the next deal
o_CardValid  out  1  one-cycle pulse when o_Card is updated
o_Ready  out  1  deck shuffled; draws are accepted
o_Busy  out  1  init, shuffle or draw in progress
o_Empty  out  1  all 52*NUM_DECKS cards dealt
o_Remaining  out  ADDR_W  cards left to deal

Behaviour:
- Local constant DECK_SIZE = 52*NUM_DECKS. RAM has synchronous read with 1-cycle latency and one port.
- Reset state:
  - All outputs 0, o_Remaining = 0.
  - FSM in IDLE, LFSR = 16'hACE1.
  - RAM contents are don't-care.
- LFSR: 16-bit Galois, mask 16'hB400, advances one step per PICK cycle.
  - Loaded on i_Start with i_Seed zero-extended.
  - A zero seed loads 16'hACE1.
- FSM states: IDLE, INIT, PICK, RD_I, RD_J, WR_I, WR_J, READY, DRAW_RD, DRAW_OUT.
- IDLE:
  - i_Start -> INIT, o_Busy = 1.
  - i_Draw is ignored.
- INIT:
  - Writes entry k = (k mod 13) + 1 for k = 0..DECK_SIZE-1, one write per cycle, DECK_SIZE cycles.
  - Sets i = DECK_SIZE-1, then goes to PICK.
- PICK:
  - Candidate j = LFSR[ADDR_W-1:0].
  - If j > i, stay in PICK (rejection sampling; the LFSR has already advanced).
  - If j <= i, go to RD_I.
- Swap sequence:
  - RD_I reads mem[i], RD_J reads mem[j]; each read value is registered.
  - WR_I writes mem[i] = old mem[j]; WR_J writes mem[j] = old mem[i].
  - j == i is legal and leaves the RAM unchanged.
  - After WR_J: if i == 1, go to READY; otherwise decrement i and go to PICK.
- Entering READY: o_Ready = 1, o_Busy = 0, o_Remaining = DECK_SIZE, o_Empty = 0, deal pointer p = 0.
- Draw, accepted in READY when o_Empty = 0:
  - Cycle N: i_Draw high -> DRAW_RD, o_Busy = 1.
  - Cycle N+1: read mem[p] -> DRAW_OUT.
  - Cycle N+2: o_Card updated, o_CardValid = 1, p += 1, o_Remaining -= 1, back to READY, o_Busy = 0.
  - Minimum draw-to-draw spacing is 3 cycles; i_Draw while o_Busy is ignored and not queued.
- Empty deck: when o_Remaining reaches 0, o_Empty = 1 in the same cycle as the final o_CardValid.
  - Later draws are ignored; o_CardValid stays 0 and o_Card holds.
- i_Start has priority over i_Draw in every state, including mid-shuffle and mid-draw. It reseeds and restarts INIT the next cycle, and clears o_Ready, o_Empty, o_Remaining and o_CardValid.
- i_Reset has priority over everything.
- Determinism: the same seed gives an identical deal sequence.
- Multiset invariant: after any completed shuffle, each value 1..13 appears exactly 4*NUM_DECKS times.

Optional Feature:
CUT_CARD_EN.
- Defined:
  - Adds parameter CUT_POS (default 3*DECK_SIZE/4) and output o_CutReached (1 bit).
  - o_CutReached rises together with the o_CardValid of card number CUT_POS (1-based).
  - It stays high until i_Start or i_Reset.
  - Dealing continues normally past the cut.
- Undefined: the port and parameter are absent; no other behaviour changes.

Test Plan:
- Reset: assert i_Reset 2 cycles, NUM_DECKS = 1 -> all outputs 0, LFSR = 16'hACE1, i_Draw ignored in IDLE.
- Shuffle integrity: i_Start with i_Seed = 12'h5A3, then draw 52 -> exactly 52 o_CardValid pulses; each value 1..13 seen 4 times; o_Empty = 1 on the 52nd pulse; o_Remaining 52 -> 0.
- Determinism and seed-zero rule:
  - Seed 12'h5A3 twice -> identical 52-card sequences.
  - Seed 12'h5A4 -> a different sequence.
  - Seed 0 equals seed 16'hACE1, run with SEED_W = 16.
- Draw timing and over-draw:
  - Draw at cycle N -> o_CardValid exactly at N+2.
  - A second i_Draw at N+1 is ignored.
  - A 53rd draw gives no pulse and o_Card unchanged.
- Mid-operation restart: i_Start during PICK, and i_Reset during DRAW_RD -> clean restart; a following full deal still passes the multiset check.
- NUM_DECKS = 2, ADDR_W = 7, CUT_CARD_EN with CUT_POS = 78:
  - 104 cards dealt, each value seen 8 times.
  - o_CutReached rises on the 78th o_CardValid and stays high.

Source files
------------

// File: rtl/multi_deck_shuffler.sv
// Multi-deck card shuffler: RAM init, LFSR-driven Fisher-Yates shuffle, then single-card dealing.
// Optional cut-card marker is enabled by defining CUT_CARD_EN.
module multi_deck_shuffler #(
    parameter int unsigned NUM_DECKS = 1,
    parameter int unsigned CARD_W    = 4,
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned SEED_W    = 12
`ifdef CUT_CARD_EN
    ,
    parameter int unsigned CUT_POS   = (3 * 52 * NUM_DECKS) / 4
`endif
) (
    input  logic              clk,
    input  logic              i_Reset,
    input  logic              i_Start,
    input  logic [SEED_W-1:0] i_Seed,
    input  logic              i_Draw,
    output logic [CARD_W-1:0] o_Card,
    output logic              o_CardValid,
    output logic              o_Ready,
    output logic              o_Busy,
    output logic              o_Empty,
    output logic [ADDR_W-1:0] o_Remaining
`ifdef CUT_CARD_EN
    ,
    output logic              o_CutReached
`endif
);

    localparam int unsigned DECK_SIZE = 52 * NUM_DECKS;
    localparam int unsigned MEM_DEPTH = 2 ** ADDR_W;
    localparam logic [15:0] LFSR_INIT = 16'hACE1;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [3:0] {
        StIdle, StInit, StPick, StRdI, StRdJ, StWrI, StWrJ, StReady, StDrawRd, StDrawOut
    } stateT;

    stateT             stateQ, stateD;
    logic [15:0]       lfsrQ, lfsrD, lfsrNext;
    logic [ADDR_W-1:0] iQ, iD, jQ, jD, kQ, kD, pQ, pD, remainingQ, remainingD;
    logic [CARD_W-1:0] initValQ, initValD, valIQ, valID, cardQ, cardD;
    logic              cardValidQ, cardValidD, readyQ, readyD, emptyQ, emptyD;
`ifdef CUT_CARD_EN
    logic              cutQ, cutD;
`endif

    logic [CARD_W-1:0] mem [MEM_DEPTH];
    logic [CARD_W-1:0] rdData, memWdata;
    logic [ADDR_W-1:0] memAddr;
    logic              memWe;

    // Single-port RAM, read-before-write, one-cycle read latency
    always_ff @(posedge clk) begin
        if (memWe) mem[memAddr] <= memWdata;
        rdData <= mem[memAddr];
    end

    assign lfsrNext = {1'b0, lfsrQ[15:1]} ^ (lfsrQ[0] ? LFSR_MASK : 16'h0000);

    always_comb begin
        memAddr  = pQ;
        memWe    = 1'b0;
        memWdata = valIQ;
        case (stateQ)
            StInit: begin
                memAddr  = kQ;
                memWe    = 1'b1;
                memWdata = initValQ;
            end
            StRdI:  memAddr = iQ;
            StRdJ:  memAddr = jQ;
            StWrI: begin
                memAddr  = iQ;
                memWe    = 1'b1;
                memWdata = rdData;
            end
            StWrJ: begin
                memAddr  = jQ;
                memWe    = 1'b1;
                memWdata = valIQ;
            end
            default: ;
        endcase
    end

    always_comb begin
        stateD     = stateQ;
        lfsrD      = lfsrQ;
        iD         = iQ;
        jD         = jQ;
        kD         = kQ;
        pD         = pQ;
        remainingD = remainingQ;
        initValD   = initValQ;
        valID      = valIQ;
        cardD      = cardQ;
        cardValidD = 1'b0;
        readyD     = readyQ;
        emptyD     = emptyQ;
`ifdef CUT_CARD_EN
        cutD       = cutQ;
`endif
        if (i_Start) begin
            stateD     = StInit;
            lfsrD      = (i_Seed == '0) ? LFSR_INIT : 16'(i_Seed);
            kD         = '0;
            initValD   = CARD_W'(1);
            readyD     = 1'b0;
            emptyD     = 1'b0;
            remainingD = '0;
`ifdef CUT_CARD_EN
            cutD       = 1'b0;
`endif
        end else begin
            case (stateQ)
                StInit: begin
                    kD       = kQ + 1'b1;
                    initValD = (initValQ == CARD_W'(13)) ? CARD_W'(1) : initValQ + 1'b1;
                    if (kQ == ADDR_W'(DECK_SIZE - 1)) begin
                        iD     = ADDR_W'(DECK_SIZE - 1);
                        stateD = StPick;
                    end
                end
                StPick: begin
                    // Rejection sampling: an out-of-range candidate just costs another cycle
                    lfsrD = lfsrNext;
                    if (lfsrQ[ADDR_W-1:0] <= iQ) begin
                        jD     = lfsrQ[ADDR_W-1:0];
                        stateD = StRdI;
                    end
                end
                StRdI: stateD = StRdJ;
                StRdJ: begin
                    valID  = rdData;
                    stateD = StWrI;
                end
                StWrI: stateD = StWrJ;
                StWrJ: begin
                    if (iQ == ADDR_W'(1)) begin
                        stateD     = StReady;
                        readyD     = 1'b1;
                        emptyD     = 1'b0;
                        remainingD = ADDR_W'(DECK_SIZE);
                        pD         = '0;
                    end else begin
                        iD     = iQ - 1'b1;
                        stateD = StPick;
                    end
                end
                StReady: if (i_Draw && !emptyQ) stateD = StDrawRd;
                StDrawRd: begin
                    cardD      = rdData;
                    cardValidD = 1'b1;
                    pD         = pQ + 1'b1;
                    remainingD = remainingQ - 1'b1;
                    emptyD     = (remainingQ == ADDR_W'(1));
`ifdef CUT_CARD_EN
                    if (pQ == ADDR_W'(CUT_POS - 1)) cutD = 1'b1;
`endif
                    stateD     = StDrawOut;
                end
                StDrawOut: stateD = StReady;
                default: stateD = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_Reset) begin
            stateQ     <= StIdle;
            lfsrQ      <= LFSR_INIT;
            iQ         <= '0;
            jQ         <= '0;
            kQ         <= '0;
            pQ         <= '0;
            remainingQ <= '0;
            initValQ   <= '0;
            valIQ      <= '0;
            cardQ      <= '0;
            cardValidQ <= 1'b0;
            readyQ     <= 1'b0;
            emptyQ     <= 1'b0;
`ifdef CUT_CARD_EN
            cutQ       <= 1'b0;
`endif
        end else begin
            stateQ     <= stateD;
            lfsrQ      <= lfsrD;
            iQ         <= iD;
            jQ         <= jD;
            kQ         <= kD;
            pQ         <= pD;
            remainingQ <= remainingD;
            initValQ   <= initValD;
            valIQ      <= valID;
            cardQ      <= cardD;
            cardValidQ <= cardValidD;
            readyQ     <= readyD;
            emptyQ     <= emptyD;
`ifdef CUT_CARD_EN
            cutQ       <= cutD;
`endif
        end
    end

    assign o_Card      = cardQ;
    assign o_CardValid = cardValidQ;
    assign o_Ready     = readyQ;
    assign o_Empty     = emptyQ;
    assign o_Remaining = remainingQ;
    assign o_Busy      = stateQ inside {StInit, StPick, StRdI, StRdJ, StWrI, StWrJ, StDrawRd};
`ifdef CUT_CARD_EN
    assign o_CutReached = cutQ;
`endif

endmodule

// File: tb/tb_multi_deck_shuffler.sv
// Randomized self-checking bench for multi_deck_shuffler; two instances (1 deck / 2 decks),
// expected deals come from a queue-based Fisher-Yates reference model.
module tb_multi_deck_shuffler;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        aReset, aStart, aDraw, aValid, aReady, aBusy, aEmpty;
    logic [11:0] aSeed;
    logic [3:0]  aCard;
    logic [8:0]  aRem;

    logic        bReset, bStart, bDraw, bValid, bReady, bBusy, bEmpty;
    logic [15:0] bSeed;
    logic [3:0]  bCard;
    logic [6:0]  bRem;
`ifdef CUT_CARD_EN
    logic        bCut;
`endif

    multi_deck_shuffler #(.NUM_DECKS(1), .CARD_W(4), .ADDR_W(9), .SEED_W(12)) dutA (
        .clk(clk), .i_Reset(aReset), .i_Start(aStart), .i_Seed(aSeed), .i_Draw(aDraw),
        .o_Card(aCard), .o_CardValid(aValid), .o_Ready(aReady), .o_Busy(aBusy),
        .o_Empty(aEmpty), .o_Remaining(aRem)
`ifdef CUT_CARD_EN
        , .o_CutReached()
`endif
    );

    multi_deck_shuffler #(
        .NUM_DECKS(2), .CARD_W(4), .ADDR_W(7), .SEED_W(16)
`ifdef CUT_CARD_EN
        , .CUT_POS(78)
`endif
    ) dutB (
        .clk(clk), .i_Reset(bReset), .i_Start(bStart), .i_Seed(bSeed), .i_Draw(bDraw),
        .o_Card(bCard), .o_CardValid(bValid), .o_Ready(bReady), .o_Busy(bBusy),
        .o_Empty(bEmpty), .o_Remaining(bRem)
`ifdef CUT_CARD_EN
        , .o_CutReached(bCut)
`endif
    );

    int nChecks = 0;
    int nErrors = 0;
    int model[$];
    int dealt[$];
    int seqFirst[$];
    int seqZero[$];
    int hist[16];

    task automatic checkVal(input string tag, input int got, input int exp);
        nChecks++;
        if (got != exp) begin
            nErrors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference: plain Fisher-Yates over a queue, candidate taken before each LFSR step
    function automatic void buildModel(input int nDecks, input int addrW, input int unsigned seed);
        int n = 52 * nDecks;
        int unsigned lfsr;
        int unsigned j;
        int tmp;
        model.delete();
        for (int k = 0; k < n; k++) model.push_back(k % 13 + 1);
        lfsr = (seed == 0) ? 32'hACE1 : seed;
        for (int i = n - 1; i >= 1; i--) begin
            do begin
                j = lfsr % (32'd1 << addrW);
                lfsr = (lfsr >> 1) ^ (((lfsr % 2) == 1) ? 32'hB400 : 32'h0);
            end while (int'(j) > i);
            tmp = model[i];
            model[i] = model[j];
            model[j] = tmp;
        end
    endfunction

    function automatic int countDiff(input int x[$], input int y[$]);
        int d = (x.size() > y.size()) ? x.size() - y.size() : y.size() - x.size();
        for (int k = 0; k < x.size() && k < y.size(); k++) if (x[k] != y[k]) d++;
        return d;
    endfunction

    function automatic int curValid(input bit selB); return selB ? int'(bValid) : int'(aValid); endfunction
    function automatic int curCard(input bit selB);  return selB ? int'(bCard)  : int'(aCard);  endfunction
    function automatic int curRem(input bit selB);   return selB ? int'(bRem)   : int'(aRem);   endfunction
    function automatic int curEmpty(input bit selB); return selB ? int'(bEmpty) : int'(aEmpty); endfunction
    function automatic int curReady(input bit selB); return selB ? int'(bReady) : int'(aReady); endfunction
    function automatic int curBusy(input bit selB);  return selB ? int'(bBusy)  : int'(aBusy);  endfunction

    task automatic setDraw(input bit selB, input logic v);
        if (selB) bDraw = v; else aDraw = v;
    endtask

    task automatic startDut(input bit selB, input int unsigned seed);
        @(posedge clk); #1;
        if (selB) begin bStart = 1'b1; bSeed = 16'(seed); end
        else      begin aStart = 1'b1; aSeed = 12'(seed); end
        @(posedge clk); #1;
        aStart = 1'b0;
        bStart = 1'b0;
    endtask

    task automatic doDraw(input bit selB, output int v, output int c);
        @(posedge clk); #1; setDraw(selB, 1'b1);
        @(posedge clk); #1; setDraw(selB, 1'b0);
        @(posedge clk); #1;
        v = curValid(selB);
        c = curCard(selB);
    endtask

    task automatic waitReady(input bit selB);
        bit done = 1'b0;
        for (int t = 0; t < 40000 && !done; t++) begin
            @(posedge clk); #1;
            if (curReady(selB) != 0) done = 1'b1;
        end
        if (!done) checkVal("ready_timeout", 0, 1);
    endtask

    task automatic prepareDeal(input bit selB, input int nDecks, input int addrW,
                               input int unsigned seed);
        buildModel(nDecks, addrW, seed);
        startDut(selB, seed);
        checkVal("start_busy", curBusy(selB), 1);
        checkVal("start_ready", curReady(selB), 0);
        checkVal("start_rem", curRem(selB), 0);
        waitReady(selB);
        checkVal("rdy_rem", curRem(selB), 52 * nDecks);
        checkVal("rdy_empty", curEmpty(selB), 0);
        checkVal("rdy_busy", curBusy(selB), 0);
`ifdef CUT_CARD_EN
        if (selB) checkVal("cut_pre", int'(bCut), 0);
`endif
        foreach (hist[v]) hist[v] = 0;
        dealt.delete();
    endtask

    task automatic dealRest(input bit selB, input int n, input int from);
        int v, c;
        for (int k = from; k < n; k++) begin
            doDraw(selB, v, c);
            checkVal("deal_valid", v, 1);
            checkVal("deal_card", c, model[k]);
            checkVal("deal_rem", curRem(selB), n - 1 - k);
            checkVal("deal_empty", curEmpty(selB), (k == n - 1) ? 1 : 0);
`ifdef CUT_CARD_EN
            if (selB) checkVal("cut_flag", int'(bCut), (k + 1 >= 78) ? 1 : 0);
`endif
            hist[c]++;
            dealt.push_back(c);
        end
        for (int val = 1; val <= 13; val++) checkVal("multiset", hist[val], n / 13);
    endtask

    initial begin
        int v, c, anyV;
        aReset = 1'b1; aStart = 1'b0; aDraw = 1'b0; aSeed = '0;
        bReset = 1'b1; bStart = 1'b0; bDraw = 1'b0; bSeed = '0;
        repeat (2) @(posedge clk);
        #1;
        aReset = 1'b0;
        bReset = 1'b0;
        checkVal("rst_card", int'(aCard), 0);
        checkVal("rst_valid", int'(aValid), 0);
        checkVal("rst_ready", int'(aReady), 0);
        checkVal("rst_busy", int'(aBusy), 0);
        checkVal("rst_empty", int'(aEmpty), 0);
        checkVal("rst_rem", int'(aRem), 0);
        checkVal("rst_lfsr", int'(dutA.lfsrQ), 'hACE1);

        // Draw in IDLE must do nothing
        aDraw = 1'b1;
        @(posedge clk); #1; aDraw = 1'b0;
        anyV = 0;
        repeat (3) begin
            @(posedge clk); #1;
            anyV |= int'(aValid);
        end
        checkVal("idle_draw_valid", anyV, 0);
        checkVal("idle_busy", int'(aBusy), 0);
        checkVal("idle_rem", int'(aRem), 0);

        // First full deal, then over-draw
        prepareDeal(1'b0, 1, 9, 32'h5A3);
        dealRest(1'b0, 52, 0);
        seqFirst = dealt;
        doDraw(1'b0, v, c);
        checkVal("over_valid", v, 0);
        checkVal("over_card", c, model[51]);
        checkVal("over_rem", int'(aRem), 0);
        checkVal("over_empty", int'(aEmpty), 1);

        // Same seed again, with a cycle-exact look at the first draw
        prepareDeal(1'b0, 1, 9, 32'h5A3);
        @(posedge clk); #1; aDraw = 1'b1;
        @(posedge clk); #1;
        checkVal("t_valid_n1", int'(aValid), 0);
        checkVal("t_busy_n1", int'(aBusy), 1);
        @(posedge clk); #1; aDraw = 1'b0;
        checkVal("t_valid_n2", int'(aValid), 1);
        checkVal("t_card", int'(aCard), model[0]);
        hist[aCard]++;
        dealt.push_back(int'(aCard));
        @(posedge clk); #1;
        checkVal("t_valid_n3", int'(aValid), 0);
        repeat (3) @(posedge clk);
        #1;
        checkVal("t_rem_after", int'(aRem), 51);
        dealRest(1'b0, 52, 1);
        checkVal("determinism", countDiff(dealt, seqFirst), 0);

        prepareDeal(1'b0, 1, 9, 32'h5A4);
        dealRest(1'b0, 52, 0);
        checkVal("seed_differs", (countDiff(dealt, seqFirst) > 0) ? 1 : 0, 1);

        // Restart while shuffling
        startDut(1'b0, $urandom_range(1, 4095));
        repeat (55) @(posedge clk);
        prepareDeal(1'b0, 1, 9, $urandom_range(1, 4095));
        dealRest(1'b0, 52, 0);

        // Reset while a draw is in flight
        prepareDeal(1'b0, 1, 9, $urandom_range(1, 4095));
        @(posedge clk); #1; aDraw = 1'b1;
        @(posedge clk); #1; aDraw = 1'b0; aReset = 1'b1;
        @(posedge clk); #1; aReset = 1'b0;
        checkVal("mid_rst_valid", int'(aValid), 0);
        checkVal("mid_rst_card", int'(aCard), 0);
        checkVal("mid_rst_ready", int'(aReady), 0);
        checkVal("mid_rst_busy", int'(aBusy), 0);
        checkVal("mid_rst_rem", int'(aRem), 0);
        prepareDeal(1'b0, 1, 9, $urandom_range(0, 4095));
        dealRest(1'b0, 52, 0);

        // Two decks: zero seed must match the default LFSR seed
        prepareDeal(1'b1, 2, 7, 0);
        dealRest(1'b1, 104, 0);
        seqZero = dealt;
        prepareDeal(1'b1, 2, 7, 32'hACE1);
        dealRest(1'b1, 104, 0);
        checkVal("seed_zero_eq", countDiff(dealt, seqZero), 0);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
